// File: rtl/fft_pkg.sv
// Shared FFT pipeline types: lane vectors, sample and CBFP index widths.
package fft_pkg;

   localparam int unsigned ARRAY_SIZE = 16;
   localparam int unsigned DW         = 11;
   localparam int unsigned CNT_SIZE   = 5;

   typedef logic signed [DW-1:0] sample_t;
   typedef sample_t              lane_vec_t [ARRAY_SIZE];
   typedef logic [CNT_SIZE-1:0]  cbfp_idx_t;

endpackage

// File: rtl/bfly_pair_store.sv
// Small register file holding the first half of a butterfly group until its partner arrives.
module bfly_pair_store
   import fft_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  lane_vec_t       i_wre,
   input  lane_vec_t       i_wim,
   input  cbfp_idx_t       i_widx,
   input  logic [AW-1:0]   i_raddr,
   output lane_vec_t       o_rre,
   output lane_vec_t       o_rim,
   output cbfp_idx_t       o_ridx
);

   lane_vec_t r_re  [DEPTH];
   lane_vec_t r_im  [DEPTH];
   cbfp_idx_t r_idx [DEPTH];

   // Write port; contents need no reset since a slot is always written before it is read.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_re[i_waddr]  <= i_wre;
         r_im[i_waddr]  <= i_wim;
         r_idx[i_waddr] <= i_widx;
      end
   end

   assign o_rre  = r_re[i_raddr];
   assign o_rim  = r_im[i_raddr];
   assign o_ridx = r_idx[i_raddr];

endmodule

// File: rtl/m1_bfly_pair_buffer.sv
// Regroups the CBFP beat stream into radix-2 pairs: beat k of each group meets beat k+HALF_BEATS.
module m1_bfly_pair_buffer
   import fft_pkg::*;
#(
   parameter  int unsigned HALF_BEATS = 4,
   localparam int unsigned SLOT_W     = $clog2(HALF_BEATS),
   localparam int unsigned BEAT_W     = SLOT_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic              frame_start,
   input  lane_vec_t         din_re,
   input  lane_vec_t         din_im,
   input  cbfp_idx_t         idx_in,
   output logic              valid_out,
   output lane_vec_t         dout_a_re,
   output lane_vec_t         dout_a_im,
   output lane_vec_t         dout_b_re,
   output lane_vec_t         dout_b_im,
   output cbfp_idx_t         idx_a,
   output cbfp_idx_t         idx_b,
   output logic [SLOT_W-1:0] pair_beat,
   output logic              frame_err
);

   logic [BEAT_W-1:0] r_beat_cnt;
   logic [BEAT_W-1:0] w_eff_cnt;
   logic              w_start;
   logic              w_fill;
   logic              w_drain;
   lane_vec_t         w_rd_re;
   lane_vec_t         w_rd_im;
   cbfp_idx_t         w_rd_idx;

   // frame_start re-aligns the current beat to position 0 of a fresh group.
   assign w_start   = valid_in & frame_start;
   assign w_eff_cnt = w_start ? '0 : r_beat_cnt;
   assign w_fill    = valid_in & ~w_eff_cnt[BEAT_W-1];
   // A realigned beat is always a FILL beat, so it never drains a stale slot.
   assign w_drain   = valid_in & ~w_start & r_beat_cnt[BEAT_W-1];

   bfly_pair_store #(
      .DEPTH (HALF_BEATS)
   ) u_store (
      .clk     (clk),
      .i_we    (w_fill & ~rst),
      .i_waddr (w_eff_cnt[SLOT_W-1:0]),
      .i_wre   (din_re),
      .i_wim   (din_im),
      .i_widx  (idx_in),
      .i_raddr (r_beat_cnt[SLOT_W-1:0]),
      .o_rre   (w_rd_re),
      .o_rim   (w_rd_im),
      .o_ridx  (w_rd_idx)
   );

   // Beat counter, error pulse and pair output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat_cnt <= '0;
         valid_out  <= 1'b0;
         frame_err  <= 1'b0;
         dout_a_re  <= '{default: '0};
         dout_a_im  <= '{default: '0};
         dout_b_re  <= '{default: '0};
         dout_b_im  <= '{default: '0};
         idx_a      <= '0;
         idx_b      <= '0;
         pair_beat  <= '0;
      end else begin
         valid_out <= w_drain;
         frame_err <= w_start & (r_beat_cnt != '0);
         if (valid_in) begin
            r_beat_cnt <= w_eff_cnt + BEAT_W'(1);
         end
         if (w_drain) begin
            dout_a_re <= w_rd_re;
            dout_a_im <= w_rd_im;
            dout_b_re <= din_re;
            dout_b_im <= din_im;
            idx_a     <= w_rd_idx;
            idx_b     <= idx_in;
            pair_beat <= r_beat_cnt[SLOT_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_m1_bfly_pair_buffer.sv
// Scoreboard bench for the butterfly pair buffer.
module tb_m1_bfly_pair_buffer;
   import fft_pkg::*;

   localparam int LW = DW * ARRAY_SIZE;
   localparam int SW = 4 * LW + 2 * CNT_SIZE + 2;
   typedef logic [LW-1:0] flat_t;
   typedef logic [SW-1:0] snap_t;

   logic       clk = 1'b0;
   logic       rst, valid_in, frame_start;
   lane_vec_t  din_re, din_im;
   cbfp_idx_t  idx_in;
   logic       valid_out, frame_err;
   lane_vec_t  dout_a_re, dout_a_im, dout_b_re, dout_b_im;
   cbfp_idx_t  idx_a, idx_b;
   logic [1:0] pair_beat;

   m1_bfly_pair_buffer #(.HALF_BEATS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .valid_in    (valid_in),
      .frame_start (frame_start),
      .din_re      (din_re),
      .din_im      (din_im),
      .idx_in      (idx_in),
      .valid_out   (valid_out),
      .dout_a_re   (dout_a_re),
      .dout_a_im   (dout_a_im),
      .dout_b_re   (dout_b_re),
      .dout_b_im   (dout_b_im),
      .idx_a       (idx_a),
      .idx_b       (idx_b),
      .pair_beat   (pair_beat),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   int    n_vec = 0, n_err = 0, n_pairs = 0, n_ferr = 0;
   bit    mon_en = 0;
   logic  exp_vo = 0, exp_err = 0;
   snap_t sb_q [$];

   // Reference model state
   int        m_cnt = 0;
   flat_t     m_re [4];
   flat_t     m_im [4];
   cbfp_idx_t m_ix [4];

   function automatic snap_t snap();
      flat_t ar, ai, br, bi;
      for (int j = 0; j < ARRAY_SIZE; j++) begin
         ar[j*DW +: DW] = dout_a_re[j];
         ai[j*DW +: DW] = dout_a_im[j];
         br[j*DW +: DW] = dout_b_re[j];
         bi[j*DW +: DW] = dout_b_im[j];
      end
      return {ar, ai, br, bi, idx_a, idx_b, pair_beat};
   endfunction

   function automatic flat_t ramp(int k, bit neg);
      flat_t f;
      for (int j = 0; j < ARRAY_SIZE; j++) begin
         f[j*DW +: DW] = neg ? DW'(-(16 * k + j)) : DW'(16 * k + j);
      end
      return f;
   endfunction

   function automatic flat_t fill_const(int v);
      flat_t f;
      for (int j = 0; j < ARRAY_SIZE; j++) f[j*DW +: DW] = DW'(v);
      return f;
   endfunction

   function automatic flat_t rnd();
      flat_t f;
      for (int j = 0; j < ARRAY_SIZE; j++) f[j*DW +: DW] = DW'($urandom);
      return f;
   endfunction

   // Apply one cycle of inputs, advance the model, and return just after the sampling edge.
   task automatic drive(input bit r, input bit v, input bit fs, input flat_t re, input flat_t im,
                        input cbfp_idx_t ix);
      int s;
      rst = r; valid_in = v; frame_start = fs; idx_in = ix;
      for (int j = 0; j < ARRAY_SIZE; j++) begin
         din_re[j] = re[j*DW +: DW];
         din_im[j] = im[j*DW +: DW];
      end
      exp_vo = 0; exp_err = 0;
      if (r) begin
         m_cnt = 0;
      end else if (v) begin
         if (fs) begin
            exp_err = (m_cnt != 0);
            m_cnt   = 0;
         end
         if (m_cnt < 4) begin
            m_re[m_cnt] = re; m_im[m_cnt] = im; m_ix[m_cnt] = ix;
         end else begin
            s = m_cnt - 4;
            sb_q.push_back({m_re[s], m_im[s], re, im, m_ix[s], ix, 2'(s)});
            exp_vo = 1;
         end
         m_cnt = (m_cnt + 1) % 8;
      end
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, '0, '0, '0);
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (mon_en) begin
         n_vec++;
         if (valid_out !== exp_vo) begin
            n_err++;
            $display("FAIL valid_out: got %b expected %b at %0t", valid_out, exp_vo, $time);
         end
         n_vec++;
         if (frame_err !== exp_err) begin
            n_err++;
            $display("FAIL frame_err: got %b expected %b at %0t", frame_err, exp_err, $time);
         end
         if (frame_err === 1'b1) n_ferr++;
         if (valid_out === 1'b1) begin
            n_pairs++;
            n_vec++;
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_pair: got pair, expected none at %0t", $time);
            end else begin
               snap_t e;
               e = sb_q.pop_front();
               if (snap() !== e) begin
                  n_err++;
                  $display("FAIL pair_data: got %h expected %h", snap(), e);
               end
            end
         end
      end
   end

   task automatic test_reset();
      drive(1, 0, 0, '0, '0, '0);
      mon_en = 1;
      drive(1, 1, 1, rnd(), rnd(), 5'd9);
      n_vec++;
      if (valid_out !== 1'b0) begin
         n_err++; $display("FAIL reset_valid: got %b expected 0", valid_out);
      end
      n_vec++;
      if (frame_err !== 1'b0) begin
         n_err++; $display("FAIL reset_err: got %b expected 0", frame_err);
      end
      n_vec++;
      if (snap() !== '0) begin
         n_err++; $display("FAIL reset_outputs: got %h expected 0", snap());
      end
   endtask

   task automatic test_continuous();
      for (int k = 0; k < 8; k++) begin
         drive(0, 1, k == 0, ramp(k, 0), ramp(k, 1), 5'(k));
         if (k >= 4) begin
            n_vec++;
            if (dout_a_re[3] !== sample_t'(16 * (k - 4) + 3) || dout_b_im[3] !== sample_t'(-(16 * k + 3))
                || idx_a !== 5'(k - 4) || idx_b !== 5'(k)) begin
               n_err++;
               $display("FAIL continuous_pair%0d: got a_re3=%0d b_im3=%0d idx=%0d/%0d expected %0d %0d %0d/%0d",
                        k - 4, dout_a_re[3], dout_b_im[3], idx_a, idx_b,
                        16 * (k - 4) + 3, -(16 * k + 3), k - 4, k);
            end
         end
      end
   endtask

   task automatic test_gaps();
      snap_t held;
      int p0;
      held = snap();
      p0 = n_pairs;
      for (int k = 0; k < 4; k++) drive(0, 1, 0, ramp(k, 0), ramp(k, 1), 5'(k));
      for (int k = 0; k < 4; k++) idle();
      n_vec++;
      if (snap() !== held) begin
         n_err++; $display("FAIL gap_hold: got %h expected %h", snap(), held);
      end
      for (int k = 4; k < 8; k++) begin
         drive(0, 1, 0, ramp(k, 0), ramp(k, 1), 5'(k));
         if (k < 7) idle();
      end
      n_vec++;
      if (n_pairs - p0 !== 4) begin
         n_err++; $display("FAIL gap_pairs: got %0d expected 4", n_pairs - p0);
      end
   endtask

   task automatic test_extremes();
      for (int k = 0; k < 8; k++) begin
         drive(0, 1, 0, fill_const(k < 4 ? -1024 : 1023), fill_const(k < 4 ? -1024 : 1023), 5'(k));
      end
      n_vec++;
      if (dout_a_re[0] !== sample_t'(-1024) || dout_b_im[15] !== sample_t'(1023)) begin
         n_err++;
         $display("FAIL extremes: got a_re0=%0d b_im15=%0d expected -1024 1023",
                  dout_a_re[0], dout_b_im[15]);
      end
   endtask

   task automatic test_frame_err();
      int p0;
      p0 = n_pairs;
      for (int k = 0; k < 3; k++) drive(0, 1, 0, rnd(), rnd(), 5'(k));
      drive(0, 1, 1, ramp(0, 0), ramp(0, 1), 5'd0);
      n_vec++;
      if (frame_err !== 1'b1) begin
         n_err++; $display("FAIL frame_err_pulse: got %b expected 1", frame_err);
      end
      drive(0, 1, 0, ramp(1, 0), ramp(1, 1), 5'd1);
      n_vec++;
      if (frame_err !== 1'b0) begin
         n_err++; $display("FAIL frame_err_width: got %b expected 0", frame_err);
      end
      for (int k = 2; k < 8; k++) drive(0, 1, 0, ramp(k, 0), ramp(k, 1), 5'(k));
      n_vec++;
      if (n_pairs - p0 !== 4) begin
         n_err++; $display("FAIL frame_err_pairs: got %0d expected 4", n_pairs - p0);
      end
   endtask

   task automatic test_reset_mid();
      int p0;
      for (int k = 0; k < 5; k++) drive(0, 1, 0, rnd(), rnd(), 5'(k));
      drive(1, 1, 0, rnd(), rnd(), 5'd5);
      n_vec++;
      if (valid_out !== 1'b0 || snap() !== '0) begin
         n_err++;
         $display("FAIL reset_mid: got valid=%b outputs=%h expected 0 and 0", valid_out, snap());
      end
      p0 = n_pairs;
      for (int k = 0; k < 8; k++) drive(0, 1, 0, rnd(), rnd(), 5'(k + 8));
      n_vec++;
      if (n_pairs - p0 !== 4) begin
         n_err++; $display("FAIL reset_mid_pairs: got %0d expected 4", n_pairs - p0);
      end
   endtask

   task automatic test_back_to_back();
      int p0, e0;
      p0 = n_pairs;
      e0 = n_ferr;
      for (int k = 0; k < 64; k++) drive(0, 1, k == 0, rnd(), rnd(), 5'($urandom));
      idle();
      n_vec++;
      if (n_pairs - p0 !== 32) begin
         n_err++; $display("FAIL b2b_pairs: got %0d expected 32", n_pairs - p0);
      end
      n_vec++;
      if (n_ferr - e0 !== 0) begin
         n_err++; $display("FAIL b2b_frame_err: got %0d pulses expected 0", n_ferr - e0);
      end
   endtask

   initial begin
      rst = 1; valid_in = 0; frame_start = 0; idx_in = '0;
      din_re = '{default: '0};
      din_im = '{default: '0};
      test_reset();
      test_continuous();
      test_gaps();
      test_extremes();
      test_frame_err();
      test_reset_mid();
      test_back_to_back();
      n_vec++;
      if (sb_q.size() !== 0) begin
         n_err++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      mon_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
